// File: rtl/fetch_decode_hazard_ctrl.sv
// fetch_decode_hazard_ctrl: Fetch/Decode pipeline control for load-use stalls, Execute redirects
// and instruction-memory waits, with saturating stall/flush event counters.
module fetch_decode_hazard_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        im_valid,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic        uses_rt_d,
    input  logic        mem_read_e,
    input  logic [4:0]  rt_e,
    input  logic        pc_src_e,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, IMWAIT = 2'd2, DRAIN = 2'd3} state_e;
    state_e      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        lu, stall_inc, flush_inc;
    assign lu = mem_read_e & (rt_e != 5'd0) & ((rt_e == rs_d) | (uses_rt_d & (rt_e == rt_d)));
    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        case (state_q)
            BOOT: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                if (pc_src_e) begin
                    pc_en      = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                    // Without data this cycle the wrong-path fetch is still in flight.
                    state_d    = im_valid ? RUN : DRAIN;
                end else if (lu) begin
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                end else if (!im_valid) begin
                    ifid_flush = 1'b1;
                    stall_inc  = 1'b1;
                    state_d    = IMWAIT;
                end else begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end
            end
            IMWAIT: begin
                if (pc_src_e) begin
                    pc_en      = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                    state_d    = DRAIN;
                end else if (im_valid) begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                    state_d = RUN;
                end else begin
                    ifid_flush = 1'b1;
                    stall_inc  = 1'b1;
                end
            end
            default: begin
                ifid_flush = 1'b1;
                stall_inc  = 1'b1;
                state_d    = im_valid ? RUN : DRAIN;
            end
        endcase
    end
    assign stall_cnt_d = (stall_inc && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    assign flush_cnt_d = (flush_inc && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= BOOT;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_fetch_decode_hazard_ctrl.sv
// tb_fetch_decode_hazard_ctrl: directed scenario tests with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
module tb_fetch_decode_hazard_ctrl;
    logic        clk = 1'b0;
    logic        reset_n, im_valid, uses_rt_d, mem_read_e, pc_src_e;
    logic [4:0]  rs_d, rt_d, rt_e;
    logic        pc_en, ifid_en, ifid_flush, idex_flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;
    int          errors = 0;
    int          checks = 0;

    fetch_decode_hazard_ctrl dut (
        .clk(clk), .reset_n(reset_n), .im_valid(im_valid), .rs_d(rs_d), .rt_d(rt_d),
        .uses_rt_d(uses_rt_d), .mem_read_e(mem_read_e), .rt_e(rt_e), .pc_src_e(pc_src_e),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    wire [3:0] outs = {pc_en, ifid_en, ifid_flush, idex_flush};

    task automatic idle_inputs();
        im_valid = 1'b1; uses_rt_d = 1'b0; mem_read_e = 1'b0; pc_src_e = 1'b0;
        rs_d = 5'd0; rt_d = 5'd0; rt_e = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #2;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
        checks++; if (outs !== 4'b0011) begin errors++; $display("FAIL reset_outs got=%b want=0011", outs); end
        checks++; if ({stall_cnt, flush_cnt} !== 32'd0) begin errors++; $display("FAIL reset_cnts got=%0h/%0h want=0/0", stall_cnt, flush_cnt); end
        reset_n = 1'b1;
        #3;
        checks++; if (state !== 2'd0 || outs !== 4'b0011) begin errors++; $display("FAIL boot_cycle got state=%0d outs=%b want 0/0011", state, outs); end
        tick();
        checks++; if (state !== 2'd1 || outs !== 4'b1100) begin errors++; $display("FAIL run_after_boot got state=%0d outs=%b want 1/1100", state, outs); end
        tick();
        checks++; if (state !== 2'd1 || {stall_cnt, flush_cnt} !== 32'd0) begin errors++; $display("FAIL run_idle got state=%0d cnts=%0h/%0h want 1 0/0", state, stall_cnt, flush_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        mem_read_e = 1'b1; rt_e = 5'd5; rs_d = 5'd5;
        #4;
        checks++; if (outs !== 4'b0001) begin errors++; $display("FAIL lu_outs got=%b want=0001", outs); end
        tick();
        idle_inputs();
        checks++; if (stall_cnt !== 16'd1 || state !== 2'd1) begin errors++; $display("FAIL lu_stall got cnt=%0d state=%0d want 1/1", stall_cnt, state); end
        #4;
        checks++; if (outs !== 4'b1100) begin errors++; $display("FAIL lu_resume got=%b want=1100", outs); end
        tick();
        mem_read_e = 1'b1; rt_e = 5'd0; rs_d = 5'd0;
        #4;
        checks++; if (outs !== 4'b1100) begin errors++; $display("FAIL lu_r0 got=%b want=1100", outs); end
        tick();
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_r0_cnt got=%0d want=1", stall_cnt); end
        rt_e = 5'd7; rs_d = 5'd3; rt_d = 5'd7; uses_rt_d = 1'b0;
        #4;
        checks++; if (outs !== 4'b1100) begin errors++; $display("FAIL lu_rt_unused got=%b want=1100", outs); end
        tick();
        uses_rt_d = 1'b1;
        #4;
        checks++; if (outs !== 4'b0001) begin errors++; $display("FAIL lu_rt_used got=%b want=0001", outs); end
        tick();
        idle_inputs();
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL lu_rt_cnt got=%0d want=2", stall_cnt); end
    endtask

    task automatic test_redirect_priority();
        do_reset();
        pc_src_e = 1'b1; mem_read_e = 1'b1; rt_e = 5'd9; rs_d = 5'd9;
        #4;
        checks++; if (outs !== 4'b1011) begin errors++; $display("FAIL redir_outs got=%b want=1011", outs); end
        tick();
        idle_inputs();
        checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0 || state !== 2'd1) begin errors++; $display("FAIL redir_cnts got f=%0d s=%0d st=%0d want 1/0/1", flush_cnt, stall_cnt, state); end
        pc_src_e = 1'b1; im_valid = 1'b0;
        #4;
        checks++; if (outs !== 4'b1011) begin errors++; $display("FAIL redir_noval_outs got=%b want=1011", outs); end
        tick();
        idle_inputs();
        checks++; if (flush_cnt !== 16'd2 || stall_cnt !== 16'd0 || state !== 2'd3) begin errors++; $display("FAIL redir_noval got f=%0d s=%0d st=%0d want 2/0/3", flush_cnt, stall_cnt, state); end
        #4;
        checks++; if (outs !== 4'b0010) begin errors++; $display("FAIL drain_outs got=%b want=0010", outs); end
        tick();
        checks++; if (state !== 2'd1 || stall_cnt !== 16'd1) begin errors++; $display("FAIL drain_exit got st=%0d s=%0d want 1/1", state, stall_cnt); end
    endtask

    task automatic test_imem_wait();
        do_reset();
        im_valid = 1'b0;
        #4;
        checks++; if (outs !== 4'b0010) begin errors++; $display("FAIL wait_run_outs got=%b want=0010", outs); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (state !== 2'd2) begin errors++; $display("FAIL wait_state%0d got=%0d want=2", i, state); end
        end
        tick();
        im_valid = 1'b1;
        checks++; if (stall_cnt !== 16'd4 || state !== 2'd2) begin errors++; $display("FAIL wait_cnt got s=%0d st=%0d want 4/2", stall_cnt, state); end
        #4;
        checks++; if (outs !== 4'b1100) begin errors++; $display("FAIL wait_valid got=%b want=1100", outs); end
        tick();
        checks++; if (state !== 2'd1 || stall_cnt !== 16'd4) begin errors++; $display("FAIL wait_exit got st=%0d s=%0d want 1/4", state, stall_cnt); end
    endtask

    task automatic test_redirect_in_wait();
        do_reset();
        im_valid = 1'b0;
        tick();
        pc_src_e = 1'b1;
        #4;
        checks++; if (state !== 2'd2 || outs !== 4'b1011) begin errors++; $display("FAIL rw_redir got st=%0d outs=%b want 2/1011", state, outs); end
        tick();
        pc_src_e = 1'b0;
        checks++; if (state !== 2'd3 || flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin errors++; $display("FAIL rw_drain got st=%0d f=%0d s=%0d want 3/1/1", state, flush_cnt, stall_cnt); end
        repeat (2) tick();
        im_valid = 1'b1;
        pc_src_e = 1'b1;
        #4;
        checks++; if (state !== 2'd3 || outs !== 4'b0010) begin errors++; $display("FAIL rw_discard got st=%0d outs=%b want 3/0010", state, outs); end
        tick();
        pc_src_e = 1'b0;
        checks++; if (state !== 2'd1 || flush_cnt !== 16'd1 || stall_cnt !== 16'd4) begin errors++; $display("FAIL rw_exit got st=%0d f=%0d s=%0d want 1/1/4", state, flush_cnt, stall_cnt); end
    endtask

    task automatic test_saturation_async_reset();
        do_reset();
        im_valid = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        checks++; if (stall_cnt !== 16'hFFFF || flush_cnt !== 16'd0) begin errors++; $display("FAIL sat got s=%0h f=%0h want ffff/0", stall_cnt, flush_cnt); end
        tick();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%0h want=ffff", stall_cnt); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (stall_cnt !== 16'd0 || state !== 2'd0 || outs !== 4'b0011) begin errors++; $display("FAIL async_reset got s=%0h st=%0d outs=%b want 0/0/0011", stall_cnt, state, outs); end
        tick();
        reset_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect_priority();
        test_imem_wait();
        test_redirect_in_wait();
        test_saturation_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
